// File: rtl/block_to_word_streamer.sv
// block_to_word_streamer: buffers up to DEPTH result blocks from a block core
// and serialises each one onto a word-wide valid/ready stream, MSW first.
module block_to_word_streamer #(
  parameter int unsigned WSIZE = 32,
  parameter int unsigned BSIZE = WSIZE * 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BSIZE-1:0]         block_in,
  input  logic                     block_valid,
  output logic                     block_ready,
  output logic [WSIZE-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     last_word,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned NWORDS = BSIZE / WSIZE;
  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW     = $clog2(NWORDS);
  localparam int unsigned OW     = $clog2(DEPTH) + 1;

  logic [BSIZE-1:0] slot_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [OW-1:0]    occ_q, occ_d;

  logic             push_c, xfer_c, pop_c;
  logic [BSIZE-1:0] head_c;
  logic [WSIZE-1:0] sel_c;

  // Flow control depends only on registered occupancy, never on word_ready.
  assign block_ready = (occ_q < OW'(DEPTH));
  assign word_valid  = (occ_q != '0);
  assign push_c      = block_valid & block_ready;
  assign xfer_c      = word_valid & word_ready;
  assign pop_c       = xfer_c & (idx_q == IW'(NWORDS - 1));

  assign occupancy   = occ_q;
  assign last_word   = word_valid & (idx_q == IW'(NWORDS - 1));
  assign word_out    = word_valid ? sel_c : '0;

  // Pick the current word of the head block; index 0 is the most significant word.
  always_comb begin
    head_c = slot_q[rd_ptr_q];
    sel_c  = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (idx_q == IW'(k)) begin
        sel_c = head_c[BSIZE-1-k*WSIZE -: WSIZE];
      end
    end
  end

  // Next-state for pointers, word index and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    occ_d    = occ_q;
    if (push_c) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (xfer_c) begin
      idx_d = pop_c ? '0 : idx_q + IW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state; reset discards every buffered block at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      occ_q    <= occ_d;
    end
  end

  // Block storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push_c) begin
      slot_q[wr_ptr_q] <= block_in;
    end
  end

endmodule

// File: tb/tb_block_to_word_streamer.sv
// Scoreboard bench for block_to_word_streamer: directed scenarios plus a
// randomized run, checked against a word-queue reference model.
module tb_block_to_word_streamer;

  localparam int unsigned WSIZE  = 32;
  localparam int unsigned BSIZE  = 128;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned NWORDS = BSIZE / WSIZE;
  localparam int unsigned OW     = $clog2(DEPTH) + 1;

  logic              clock;
  logic              reset;
  logic [BSIZE-1:0]  block_in;
  logic              block_valid;
  logic              block_ready;
  logic [WSIZE-1:0]  word_out;
  logic              word_valid;
  logic              word_ready;
  logic              last_word;
  logic [OW-1:0]     occupancy;

  block_to_word_streamer #(.WSIZE(WSIZE), .BSIZE(BSIZE), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .last_word   (last_word),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [WSIZE-1:0] w;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   blk_in_cnt = 0;
  int   blk_out_cnt = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [BSIZE-1:0] act, input logic [BSIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BSIZE-1:0] rand_block();
    logic [BSIZE-1:0] r = '0;
    for (int i = 0; i < int'(BSIZE / 32); i++) r = {r[BSIZE-33:0], 32'($urandom())};
    return r;
  endfunction

  // Reference: an accepted block becomes NWORDS expected words, MSW first.
  task automatic model_push(input logic [BSIZE-1:0] b);
    for (int k = 0; k < int'(NWORDS); k++) begin
      exp_t e;
      e.w    = WSIZE'(b >> (WSIZE * (NWORDS - 1 - k)));
      e.last = (k == int'(NWORDS) - 1);
      exp_q.push_back(e);
    end
    blk_in_cnt++;
  endtask

  // Offer a block until accepted (bounded); records it in the scoreboard.
  task automatic push_block(input logic [BSIZE-1:0] b);
    bit acc = 1'b0;
    int n = 0;
    block_valid = 1'b1;
    block_in    = b;
    while (!acc && n < 500) begin
      @(negedge clock);
      acc = block_ready;
      @(posedge clock);
      if (acc) model_push(b);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: block 0x%0h not accepted within 500 cycles", b);
    end
    block_valid = 1'b0;
    block_in    = rand_block();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_remaining", BSIZE'(exp_q.size()), '0);
  endtask

  // Monitor: compares outputs and handshake state against the model each cycle.
  always @(negedge clock) begin
    if (reset) begin
      chk("occupancy", BSIZE'(occupancy), BSIZE'(blk_in_cnt - blk_out_cnt));
      chk("block_ready", BSIZE'(block_ready), BSIZE'((blk_in_cnt - blk_out_cnt) < int'(DEPTH)));
      chk("word_valid", BSIZE'(word_valid), BSIZE'(exp_q.size() != 0));
      if (word_valid && exp_q.size() != 0) begin
        chk("word_out", BSIZE'(word_out), BSIZE'(exp_q[0].w));
        chk("last_word", BSIZE'(last_word), BSIZE'(exp_q[0].last));
        if (word_ready) begin
          if (exp_q[0].last) blk_out_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BSIZE-1:0] blk_a, blk_b, blk_c, blk_d, fixed;
    int pat[7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    fixed = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    blk_a = rand_block();
    blk_b = rand_block();
    blk_c = rand_block();
    blk_d = rand_block();

    reset       = 1'b0;
    block_valid = 1'b0;
    word_ready  = 1'b0;
    block_in    = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_occupancy", BSIZE'(occupancy), '0);
    chk("rst_block_ready", BSIZE'(block_ready), BSIZE'(1));
    chk("rst_word_valid", BSIZE'(word_valid), '0);
    chk("rst_last_word", BSIZE'(last_word), '0);
    chk("rst_word_out", BSIZE'(word_out), '0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Single block, downstream always ready.
    word_ready = 1'b1;
    push_block(fixed);
    wait_drain();

    // Same block with an irregular ready pattern.
    word_ready = 1'b0;
    push_block(fixed);
    for (int i = 0; i < 7; i++) begin
      word_ready = pat[i][0];
      @(posedge clock);
      #1;
    end
    chk("toggle_all_taken", BSIZE'(exp_q.size()), '0);
    word_ready = 1'b0;

    // Fill to DEPTH, third block held off until a slot frees.
    push_block(blk_a);
    push_block(blk_b);
    chk("full_occupancy", BSIZE'(occupancy), BSIZE'(DEPTH));
    chk("full_block_ready", BSIZE'(block_ready), '0);
    fork
      push_block(blk_c);
      begin
        repeat (2) begin
          @(posedge clock);
          #1;
        end
        word_ready = 1'b1;
      end
    join
    wait_drain();

    // Push coinciding with the final word of the only held block.
    word_ready = 1'b0;
    push_block(blk_a);
    word_ready = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    push_block(blk_b);
    chk("pushpop_occupancy", BSIZE'(occupancy), BSIZE'(1));
    chk("pushpop_word0", BSIZE'(word_out), BSIZE'(blk_b[BSIZE-1 -: WSIZE]));
    wait_drain();

    // Reset in the middle of a block.
    word_ready = 1'b1;
    push_block(blk_a);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    #1;
    chk("midrst_word_valid", BSIZE'(word_valid), '0);
    chk("midrst_word_out", BSIZE'(word_out), '0);
    chk("midrst_occupancy", BSIZE'(occupancy), '0);
    chk("midrst_block_ready", BSIZE'(block_ready), BSIZE'(1));
    exp_q.delete();
    blk_in_cnt  = 0;
    blk_out_cnt = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    push_block(blk_d);
    wait_drain();

    // Randomized traffic on both sides.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clock);
            #1;
          end
          push_block(rand_block());
        end
        done = 1'b1;
      end
      begin
        int n = 0;
        while ((!done || exp_q.size() != 0) && n < 5000) begin
          @(posedge clock);
          #1;
          word_ready = 1'($urandom_range(0, 1));
          n++;
        end
      end
    join
    chk("random_drained", BSIZE'(exp_q.size()), '0);
    chk("random_blocks_out", BSIZE'(blk_out_cnt), BSIZE'(11));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_to_word_streamer.md
Name: block_to_word_streamer

Overview:
- Output-side counterpart of the word-to-block packing path.
- Accepts BSIZE-bit result blocks from a block-oriented core (e.g. a 128-bit cipher) through a valid/ready handshake.
- Buffers up to DEPTH blocks and streams each one out as BSIZE/WSIZE words, most-significant word first, over a second valid/ready handshake.
- Sits between the block core and the word-wide bus/FIFO; upstream and downstream flow control are fully independent.

Parameters:
- WSIZE, 32: output word width in bits.
- BSIZE, WSIZE*4: input block width in bits. Must be an integer multiple of WSIZE, with NWORDS = BSIZE/WSIZE >= 2.
- DEPTH, 2: number of block slots. Must be a power of 2, >= 1.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- block_in  input  BSIZE  block data; sampled only on an accepted block handshake.
- block_valid  input  1  upstream has a block on block_in.
- block_ready  output  1  a free slot exists; block accepted when block_valid & block_ready at a clock edge.
- word_out  output  WSIZE  current word of the head block.
- word_valid  output  1  word_out holds a valid word.
- word_ready  input  1  downstream accepts the word; word transferred when word_valid & word_ready at a clock edge.
- last_word  output  1  word_out is the final word (index NWORDS-1) of its block; qualified by word_valid.
- occupancy  output  clog2(DEPTH)+1  number of blocks held, including a partially streamed block.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - occupancy=0, write pointer=0, read pointer=0, word index=0.
  - block_ready=1, word_valid=0, last_word=0, word_out=0.
  - Storage contents are don't-care.
- block_ready = (occupancy < DEPTH). It is a function of registered state only and has no combinational path from word_ready; there is no bypass when full.
- word_valid = (occupancy != 0).
- word_out:
  - When valid: slot[rd_ptr][BSIZE-1-idx*WSIZE -: WSIZE], so index 0 is the MSW.
  - When word_valid=0: word_out=0.
- last_word = word_valid & (idx == NWORDS-1).
- Push: on an accepted block, store block_in into slot[wr_ptr] and increment wr_ptr (mod DEPTH).
- Word transfer: on an accepted word, increment idx.
  - If idx == NWORDS-1: idx returns to 0, rd_ptr increments (mod DEPTH) and the block is popped.
- occupancy update per edge:
  - +1 on a push without a pop.
  - -1 on a pop without a push.
  - Unchanged when both or neither occur.
- Latency:
  - A block accepted at edge N into an empty unit gives word_valid=1 and word 0 visible after edge N.
  - With word_ready held high, one word is delivered per cycle, so NWORDS cycles per block.
  - Back-to-back blocks stream with no bubble.
- Stability: while word_valid=1 and word_ready=0, word_out and last_word hold constant.
- Boundary conditions:
  - Full (occupancy=DEPTH): block_ready=0 and block_valid is ignored. The edge that pops the last word frees a slot, and block_ready rises after that edge.
  - Simultaneous push and pop at occupancy=DEPTH-1: both take effect and occupancy is unchanged.
  - DEPTH=1: push and pop cannot coincide. block_ready=0 until the final word is taken.
  - Pointers wrap mod DEPTH; occupancy never exceeds DEPTH and never underflows.
  - Reset mid-stream: all buffered blocks are discarded immediately, word_valid drops asynchronously, and streaming after release restarts at word 0 of the next pushed block.

Test Plan:
1. Push 0x00112233_44556677_8899AABB_CCDDEEFF with word_ready=1 -> words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles; last_word only on 0xCCDDEEFF; occupancy 1->0.
2. Same block with word_ready toggling 1,0,0,1,1,0,1 -> exactly 4 transfers in order; word_out stable while stalled.
3. DEPTH=2, word_ready=0, push blocks A, B, C on successive cycles -> A and B accepted, occupancy=2, block_ready=0, C held off. Raise word_ready -> C accepted on the cycle after A's 4th word; output order is A0..A3, B0..B3, C0..C3 with no bubbles.
4. occupancy=1 with idx=3 and word_ready=1, push B on the same edge -> occupancy stays 1 and B's word 0x... appears on the next cycle.
5. After 2 of 4 words of block A, assert reset=0 for 1 cycle -> word_valid=0, word_out=0, occupancy=0 immediately. Push D after release -> D word 0 is output first.
6. Stream 10 random blocks under random valid/ready on both sides -> output word sequence equals a concatenation of the blocks MSW-first; occupancy never exceeds 2.
